// File: rtl/alu_operand_regfile_pkg.sv
// rtl/alu_operand_regfile_pkg.sv - shared widths and ALU control encodings for regfile and ALU
// Purpose: one definition of register geometry and ALU opcodes for the regfile, the ALU and their benches.
// Contents: REG_DATA_W, REG_ADDR_W, REG_ZERO, alu_ctrl_e.
package alu_operand_regfile_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_XOR = 3'b001,
        ALU_ADD = 3'b010,
        ALU_MUL = 3'b011,
        ALU_SRA = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLL = 3'b111
    } alu_ctrl_e;

endpackage

// File: rtl/alu_operand_regfile_if.sv
// rtl/alu_operand_regfile_if.sv - read/write/debug bus of the operand register file
// Purpose: bundles the two ALU read ports, the writeback port, the debug port and the write counter.
// Modports: master = core/bench side (drives indices and write data), slave = register file.
interface alu_operand_regfile_if
    import alu_operand_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
);
    logic [ADDR_W-1:0] RS1addr_i;
    logic [ADDR_W-1:0] RS2addr_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic [DATA_W-1:0] RDdata_i;
    logic              RegWrite_i;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic [31:0]       wr_count_o;

    modport master (
        output RS1addr_i, RS2addr_i, RDaddr_i, RDdata_i, RegWrite_i, dbg_addr_i,
        input  RS1data_o, RS2data_o, dbg_data_o, wr_count_o
    );

    modport slave (
        input  RS1addr_i, RS2addr_i, RDaddr_i, RDdata_i, RegWrite_i, dbg_addr_i,
        output RS1data_o, RS2data_o, dbg_data_o, wr_count_o
    );

endinterface

// File: rtl/alu_operand_regfile_read_port.sv
// rtl/alu_operand_regfile_read_port.sv - one combinational read port with x0 masking and optional forwarding
// Purpose: turns the addressed storage word into the port output.
// Ports: rd_addr_i (index), mem_word_i (storage[rd_addr_i]), wr_en_i/wr_addr_i/wr_data_i (same-cycle write),
//        rd_data_o (result).
module regfile_read_port
    import alu_operand_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter bit          BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    always_comb begin
        rd_data_o = mem_word_i;
        // Write-first forwarding; a write to x0 is dropped so it is never forwarded.
        if (BYPASS && wr_en_i && (wr_addr_i != '0) && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
        // x0 reads as zero whatever the storage holds.
        if (rd_addr_i == '0) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - 32-entry operand register file feeding the ALU
// Purpose: storage, synchronous reset and committed-write counter; three read ports (RS1, RS2, debug).
// Ports: clk_i (rising-edge clock), rst_i (synchronous active-high reset),
//        bus (slave modport: read indices, writeback port, read data, debug port, wr_count_o).
module alu_operand_regfile
    import alu_operand_regfile_pkg::*;
#(
    parameter int unsigned           DATA_W  = REG_DATA_W,
    parameter int unsigned           ADDR_W  = REG_ADDR_W,
    parameter bit                    BYPASS  = 1'b0,
    parameter logic [DATA_W-1:0]     RST_VAL = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_operand_regfile_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [31:0]       wr_count_q;
    logic [31:0]       wr_count_d;
    logic              wr_fire;

    // Writes to x0 are neither stored nor counted.
    assign wr_fire = bus.RegWrite_i && (bus.RDaddr_i != REG_ZERO[ADDR_W-1:0]);

    always_comb begin
        mem_d      = mem_q;
        wr_count_d = wr_count_q;
        if (wr_fire) begin
            mem_d[bus.RDaddr_i] = bus.RDdata_i;
            wr_count_d          = wr_count_q + 32'd1;
        end
    end

    // Reset wins over a same-cycle write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
            wr_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.wr_count_o = wr_count_q;

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs1_port (
        .rd_addr_i  (bus.RS1addr_i),
        .mem_word_i (mem_q[bus.RS1addr_i]),
        .wr_en_i    (bus.RegWrite_i),
        .wr_addr_i  (bus.RDaddr_i),
        .wr_data_i  (bus.RDdata_i),
        .rd_data_o  (bus.RS1data_o)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs2_port (
        .rd_addr_i  (bus.RS2addr_i),
        .mem_word_i (mem_q[bus.RS2addr_i]),
        .wr_en_i    (bus.RegWrite_i),
        .wr_addr_i  (bus.RDaddr_i),
        .wr_data_i  (bus.RDdata_i),
        .rd_data_o  (bus.RS2data_o)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_dbg_port (
        .rd_addr_i  (bus.dbg_addr_i),
        .mem_word_i (mem_q[bus.dbg_addr_i]),
        .wr_en_i    (bus.RegWrite_i),
        .wr_addr_i  (bus.RDaddr_i),
        .wr_data_i  (bus.RDdata_i),
        .rd_data_o  (bus.dbg_data_o)
    );

endmodule

// File: tb/tb_alu_operand_regfile.sv
// tb/tb_alu_operand_regfile.sv - bench for alu_operand_regfile, BYPASS=0 and BYPASS=1 side by side
module tb_alu_operand_regfile;
    import alu_operand_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_regfile_if bus0 ();
    alu_operand_regfile_if bus1 ();

    alu_operand_regfile #(.BYPASS(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
    alu_operand_regfile #(.BYPASS(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [31:0] ec;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] bd;
    } vec_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] ref_mem [32];
    logic [31:0] ref_cnt;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return bus0.RS1data_o;
            1: return bus0.RS2data_o;
            2: return bus0.dbg_data_o;
            3: return bus0.wr_count_o;
            4: return bus1.RS1data_o;
            5: return bus1.RS2data_o;
            6: return bus1.dbg_data_o;
            default: return bus1.wr_count_o;
        endcase
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rst = r;
        bus0.RegWrite_i = we; bus0.RDaddr_i = rd; bus0.RDdata_i = wd;
        bus0.RS1addr_i = a1;  bus0.RS2addr_i = a2; bus0.dbg_addr_i = ad;
        bus1.RegWrite_i = we; bus1.RDaddr_i = rd; bus1.RDdata_i = wd;
        bus1.RS1addr_i = a1;  bus1.RS2addr_i = a2; bus1.dbg_addr_i = ad;
    endtask

    task automatic push(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] ed, input logic [31:0] ec, input logic [31:0] b1,
                        input logic [31:0] b2, input logic [31:0] bd);
        scb.push_back('{{tag, ".rs1_b0"}, 0, e1});
        scb.push_back('{{tag, ".rs2_b0"}, 1, e2});
        scb.push_back('{{tag, ".dbg_b0"}, 2, ed});
        scb.push_back('{{tag, ".cnt_b0"}, 3, ec});
        scb.push_back('{{tag, ".rs1_b1"}, 4, b1});
        scb.push_back('{{tag, ".rs2_b1"}, 5, b2});
        scb.push_back('{{tag, ".dbg_b1"}, 6, bd});
        scb.push_back('{{tag, ".cnt_b1"}, 7, ec});
    endtask

    // Sample away from the rising edge, drain the scoreboard, then step past the next rising edge.
    task automatic settle_and_check();
        exp_t        e;
        logic [31:0] a;
        @(negedge clk);
        while (scb.size() > 0) begin
            e = scb.pop_front();
            a = actual(e.sel);
            n_cmp++;
            if (a !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, a, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd(logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : ref_mem[a];
    endfunction

    function automatic logic [31:0] ref_byp(logic [4:0] a, logic we, logic [4:0] rd, logic [31:0] wd);
        return (we && rd != 5'd0 && rd == a) ? wd : ref_rd(a);
    endfunction

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0,1, 5,32'hDEADBEEF, 5,31, 5, 32'h0,32'h0,32'h0, 0, 32'hDEADBEEF,32'h0,32'hDEADBEEF};
        vecs[1]  = '{0,1,31,32'h80000000, 5,31,31, 32'hDEADBEEF,32'h0,32'h0, 1, 32'hDEADBEEF,32'h80000000,32'h80000000};
        vecs[2]  = '{0,0, 0,32'h0,        5,31, 0, 32'hDEADBEEF,32'h80000000,32'h0, 2, 32'hDEADBEEF,32'h80000000,32'h0};
        vecs[3]  = '{0,1, 0,32'h12345678, 0, 0, 0, 32'h0,32'h0,32'h0, 2, 32'h0,32'h0,32'h0};
        vecs[4]  = '{0,0, 0,32'h0,        0, 5, 0, 32'h0,32'hDEADBEEF,32'h0, 2, 32'h0,32'hDEADBEEF,32'h0};
        vecs[5]  = '{0,1, 7,32'h1,        7, 7, 3, 32'h0,32'h0,32'h0, 2, 32'h1,32'h1,32'h0};
        vecs[6]  = '{0,1, 7,32'h9,        7, 7, 7, 32'h1,32'h1,32'h1, 3, 32'h9,32'h9,32'h9};
        vecs[7]  = '{0,0, 0,32'h0,        7, 5, 7, 32'h9,32'hDEADBEEF,32'h9, 4, 32'h9,32'hDEADBEEF,32'h9};
        vecs[8]  = '{0,1, 3,32'hAAAA,     3,31, 3, 32'h0,32'h80000000,32'h0, 4, 32'hAAAA,32'h80000000,32'hAAAA};
        vecs[9]  = '{1,1, 3,32'h5555,     3, 7, 3, 32'hAAAA,32'h9,32'hAAAA, 5, 32'h5555,32'h9,32'h5555};
        vecs[10] = '{0,0, 0,32'h0,        3, 7,31, 32'h0,32'h0,32'h0, 0, 32'h0,32'h0,32'h0};
        vecs[11] = '{0,1, 1,32'hFFFFFFFF, 1, 2, 1, 32'h0,32'h0,32'h0, 0, 32'hFFFFFFFF,32'h0,32'hFFFFFFFF};
        vecs[12] = '{0,1, 2,32'h7FFFFFFF, 1, 2, 2, 32'hFFFFFFFF,32'h0,32'h0, 1, 32'hFFFFFFFF,32'h7FFFFFFF,32'h7FFFFFFF};
        vecs[13] = '{0,0, 0,32'h0,        2, 1, 1, 32'h7FFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF, 2, 32'h7FFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF};

        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset state: every index on both ports and the debug port reads zero.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            push($sformatf("reset_x%0d", i), 0, 0, 0, 0, 0, 0, 0);
            settle_and_check();
        end

        // Directed table: readback, x0 protection, same-cycle read/write, reset collision.
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].we, vecs[k].rd, vecs[k].wd, vecs[k].a1, vecs[k].a2, vecs[k].ad);
            push($sformatf("vec%0d", k), vecs[k].e1, vecs[k].e2, vecs[k].ed, vecs[k].ec,
                 vecs[k].b1, vecs[k].b2, vecs[k].bd);
            settle_and_check();
        end

        // Random traffic against a reference model; storage now holds x1, x2 from the table.
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_mem[1] = 32'hFFFFFFFF;
        ref_mem[2] = 32'h7FFFFFFF;
        ref_cnt    = 32'd2;
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [4:0]  rd, a1, a2, ad;
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = (n % 4 == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = (n % 5 == 0) ? a1 : 5'($urandom_range(0, 31));
            ad = 5'($urandom_range(0, 31));
            drive(0, we, rd, wd, a1, a2, ad);
            push($sformatf("rand%0d", n), ref_rd(a1), ref_rd(a2), ref_rd(ad), ref_cnt,
                 ref_byp(a1, we, rd, wd), ref_byp(a2, we, rd, wd), ref_byp(ad, we, rd, wd));
            settle_and_check();
            if (we && rd != 5'd0) begin
                ref_mem[rd] = wd;
                ref_cnt     = ref_cnt + 32'd1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- 32-entry general-purpose register file directly upstream of the ALU.
- Drives the ALU's two signed 32-bit operands from two asynchronous read ports.
- Accepts one synchronous write per cycle from the writeback path, which carries the ALU result or memory data.
- Also provides a debug read port and a write counter for bench observation.

Parameters:
- DATA_W, 32, register width; must equal the ALU operand width.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- BYPASS, 0, 1 = write-first forwarding of the same-cycle write to the read ports. Must stay 0 in the single-cycle core to avoid a combinational loop through the ALU.
- RST_VAL, 32'h0, value loaded into every register on reset.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- RS1addr_i  in  ADDR_W  read index feeding the ALU data1_i.
- RS2addr_i  in  ADDR_W  read index feeding the ALU data2_i (via the immediate mux).
- RDaddr_i  in  ADDR_W  write index.
- RDdata_i  in  DATA_W  write data, normally the ALU data_o or load data.
- RegWrite_i  in  1  write enable.
- RS1data_o  out  DATA_W  register[RS1addr_i].
- RS2data_o  out  DATA_W  register[RS2addr_i].
- dbg_addr_i  in  ADDR_W  debug read index.
- dbg_data_o  out  DATA_W  register[dbg_addr_i], combinational.
- wr_count_o  out  32  number of committed writes since reset; wraps at 2**32.

Behaviour:
- Storage:
  - 2**ADDR_W words of DATA_W bits.
  - Index 0 is hardwired to zero. Reads of x0 return 0 regardless of storage. Writes to x0 are dropped and not counted.
- Reset:
  - On a rising edge with rst_i=1, all registers 1..N-1 load RST_VAL and wr_count_o loads 0.
  - rst_i dominates RegWrite_i in the same cycle: the write is lost.
  - With RST_VAL=0, all read outputs read 0 in the cycle after reset.
- Write:
  - On a rising edge with rst_i=0, RegWrite_i=1 and RDaddr_i!=0, register[RDaddr_i] <= RDdata_i and wr_count_o increments by 1.
  - The new value is visible on the read ports starting the following cycle.
- Read, BYPASS=0:
  - Purely combinational from current storage.
  - Zero-cycle latency relative to an address change.
  - A same-cycle write to the addressed register is not visible until after the edge.
- Read, BYPASS=1:
  - If RegWrite_i=1, RDaddr_i!=0 and RDaddr_i equals the read index, the port returns RDdata_i.
  - This applies independently per port, including dbg_data_o.
- Simultaneous events:
  - RS1addr_i==RS2addr_i: both ports return the identical value.
  - Write plus reads of other indices: the reads are unaffected.
- Width rules:
  - Data is stored and returned as raw bits; no sign or zero extension.
  - The ALU interprets operands as signed.
- wr_count_o: 0xFFFFFFFF + 1 wraps to 0 with no flag.
- No X-propagation: address inputs are always in range because the width is exact.

Decomposition:
- Shared package holds:
  - REG_DATA_W=32 and REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - The ALU control encodings AND=000, XOR=001, ADD=010, MUL=011, SRA=101, SUB=110, SLL=111, so regfile and ALU benches share one definition.
- One sub-module is natural: regfile_read_port. It is instantiated three times (RS1, RS2, debug) and contains the x0 masking plus the optional BYPASS mux.
- Storage, reset and counter stay in the top module.

Test Plan:
- Reset then read: assert rst_i 1 cycle, read all 32 indices on both ports -> every value 0; wr_count_o=0.
- Write/readback: write x5=0xDEADBEEF, x31=0x80000000 -> next cycle RS1(x5)=0xDEADBEEF, RS2(x31)=0x80000000; wr_count_o=2.
- x0 protection: write x0=0x12345678 -> RS1(x0)=0, dbg(x0)=0; wr_count_o unchanged.
- Same-cycle read/write, BYPASS=0: x7=1, then write x7=9 while reading x7 -> reads 1 that cycle, 9 the next.
- Same-cycle read/write, BYPASS=1: same stimulus -> reads 9 in the write cycle on both ports.
- Reset collision: x3=0xAAAA, then rst_i=1 with write x3=0x5555 in the same cycle -> x3=0 after the edge; wr_count_o=0.
